// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Resolves load-use hazards, taken-branch squashes and multi-cycle data-memory
// accesses. Also keeps a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_en,
    output logic                  pr1_en,
    output logic                  pr2_en,
    output logic                  pr3_en,
    output logic                  pr4_en,
    output logic                  pr1_flush,
    output logic                  pr2_flush,
    output logic                  pr4_bubble,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [0:0] StRun     = 1'b0;
    localparam logic [0:0] StMemWait = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q;
    logic [CNT_W-1:0]  stall_cycles_q;

    logic load_use;
    logic timeout;
    logic mem_stall;

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign timeout   = (state_q == StMemWait) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    assign mem_stall = mem_access && !mem_ready && !timeout;

    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_cycles_q;

    // Pipeline controls: reset > mem_stall > branch > load_use > normal.
    // A timeout release uses the normal priority rules but always bubbles WB so
    // the aborted access never writes back.
    always_comb begin
        mem_req    = mem_access;
        pc_en      = 1'b1;
        pr1_en     = 1'b1;
        pr2_en     = 1'b1;
        pr3_en     = 1'b1;
        pr4_en     = 1'b1;
        pr1_flush  = 1'b0;
        pr2_flush  = 1'b0;
        pr4_bubble = timeout;
        if (rst) begin
            mem_req    = 1'b0;
            pc_en      = 1'b0;
            pr1_en     = 1'b0;
            pr2_en     = 1'b0;
            pr3_en     = 1'b0;
            pr4_en     = 1'b0;
            pr4_bubble = 1'b0;
        end else if (mem_stall) begin
            pc_en      = 1'b0;
            pr1_en     = 1'b0;
            pr2_en     = 1'b0;
            pr3_en     = 1'b0;
            pr4_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            pr1_flush = 1'b1;
            pr2_flush = 1'b1;
        end else if (load_use) begin
            pc_en     = 1'b0;
            pr1_en    = 1'b0;
            pr2_flush = 1'b1;
        end
    end

    // Next FSM state and wait count; any cycle without a memory stall returns to RUN.
    always_comb begin
        state_d    = StRun;
        wait_cnt_d = '0;
        if (mem_stall) begin
            state_d    = StMemWait;
            wait_cnt_d = (state_q == StMemWait) ? wait_cnt_q + 1'b1 : WAIT_W'(1);
        end
    end

    // State, sticky error and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_q | timeout;
            if (!pc_en && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_access, mem_ready;
    logic        mem_req, pc_en, pr1_en, pr2_en, pr3_en, pr4_en;
    logic        pr1_flush, pr2_flush, pr4_bubble, mem_error;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Model state: are we inside a memory wait, how many wait cycles so far.
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stalls;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .pc_en          (pc_en),
        .pr1_en         (pr1_en),
        .pr2_en         (pr2_en),
        .pr3_en         (pr3_en),
        .pr4_en         (pr4_en),
        .pr1_flush      (pr1_flush),
        .pr2_flush      (pr2_flush),
        .pr4_bubble     (pr4_bubble),
        .mem_error      (mem_error),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_access = 0; mem_ready = 0;
    endtask

    // Called at a falling edge with inputs already applied: checks the cycle,
    // advances the model across the rising edge, returns at the next falling edge.
    task automatic tick(input string tag);
        logic [8:0]  exp_v, obs_v;
        logic [15:0] exp_s;
        bit lu, to, ms, stalled;
        #1;
        lu = 0; to = 0; ms = 0; stalled = 0;
        if (rst) begin
            exp_v    = '0;
            m_wait   = 0;
            m_waited = 0;
            m_err    = 0;
            m_stalls = 0;
        end else begin
            lu = ex_mem_read && ex_rd != 0 &&
                 (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
            to = m_wait && m_waited == TIMEOUT;
            ms = mem_access && !mem_ready && !to;
            // order: mem_req pc pr1 pr2 pr3 pr4 flush1 flush2 bubble
            if (ms)                   exp_v = {mem_access, 8'b0000_1001};
            else if (ex_branch_taken) exp_v = {mem_access, 5'b11111, 2'b11, to};
            else if (lu)              exp_v = {mem_access, 5'b00111, 2'b01, to};
            else                      exp_v = {mem_access, 5'b11111, 2'b00, to};
            stalled = ms || (!ex_branch_taken && lu);
        end
        obs_v = {mem_req, pc_en, pr1_en, pr2_en, pr3_en, pr4_en, pr1_flush, pr2_flush, pr4_bubble};
        exp_s = m_stalls[15:0];
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s ctrl: got %b want %b", tag, obs_v, exp_v);
        end
        checks++;
        assert (mem_error === m_err) else begin
            failures++;
            $error("FAIL %s mem_error: got %b want %b", tag, mem_error, m_err);
        end
        checks++;
        assert (stall_cycles === exp_s) else begin
            failures++;
            $error("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, exp_s);
        end
        @(posedge clk);
        if (!rst) begin
            if (to) m_err = 1;
            if (stalled && m_stalls < 65535) m_stalls++;
            if (ms) begin
                m_waited = m_wait ? m_waited + 1 : 1;
                m_wait   = 1;
            end else begin
                m_wait   = 0;
                m_waited = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick("reset0");
        mem_access = 1; ex_branch_taken = 1;
        tick("reset1");
        clear_inputs();
        rst = 1'b0;
        tick("idle");

        // Load-use on rs: exactly one stall cycle.
        ex_mem_read = 1; ex_rd = 5; id_rs = 5;
        tick("load_use");
        clear_inputs();
        tick("after_lu");

        // No hazard through r0, nor through rt when rt is unused.
        ex_mem_read = 1; ex_rd = 0; id_rs = 0;
        tick("rd_zero");
        ex_rd = 7; id_rs = 1; id_rt = 7; id_uses_rt = 0;
        tick("rt_unused");
        id_uses_rt = 1;
        tick("rt_used");
        clear_inputs();

        // Taken branch: flush IF/ID and ID/EX, no stall.
        ex_branch_taken = 1;
        tick("branch");
        clear_inputs();
        tick("after_br");

        // Memory access with ready three cycles after request.
        mem_access = 1;
        for (int i = 0; i < 3; i++) tick("mem_wait");
        mem_ready = 1;
        tick("mem_release");
        clear_inputs();
        tick("after_mem");
        mem_access = 1; mem_ready = 1;
        tick("mem_k0");
        clear_inputs();

        // Branch + load-use + pending memory: memory first, then branch wins.
        mem_access = 1; ex_branch_taken = 1;
        ex_mem_read = 1; ex_rd = 3; id_rs = 3;
        tick("combo_wait0");
        tick("combo_wait1");
        mem_ready = 1;
        tick("combo_release");
        clear_inputs();
        tick("after_combo");

        // Timeout: ready never comes.
        mem_access = 1;
        for (int i = 0; i < 20; i++) tick("timeout");
        clear_inputs();
        tick("err_sticky0");
        tick("err_sticky1");

        // Reset asserted in the middle of a wait.
        mem_access = 1;
        for (int i = 0; i < 3; i++) tick("pre_rst");
        rst = 1'b1;
        tick("rst_mid");
        rst = 1'b0;
        clear_inputs();
        tick("post_rst");

        // Random traffic with occasional long ready gaps.
        for (int i = 0; i < 600; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_access      = ($urandom_range(0, 2) == 0) || (i % 150 < 20);
            mem_ready       = (i % 150 < 20) ? 1'b0 : ($urandom_range(0, 9) < 6);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
